// File: rtl/pipe_stage_reg.sv
// Pipeline register between two CPU stages: valid/ready handshake, flush squash, stall-cycle counter.
// Latency: 1 cycle from accept to out_valid when the stage is free.
// Backpressure: base in_ready = ~out_valid | out_ready; with PIPE_SKID_BUF_EN a skid entry makes in_ready a flop.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Main (output-facing) register
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  // Stall-cycle counter
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

  // Saturating count of cycles where a valid payload is refused downstream; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

`ifdef PIPE_SKID_BUF_EN
  // Skid entry catches the payload accepted while main is full and stalled,
  // so in_ready depends only on a flop and never on out_ready.
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic              accept;
  logic              deliver;

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & in_ready;
  assign deliver  = valid_q & out_ready;

  // Next state: flush wins; a full skid refills main on deliver; otherwise route in_data to main or skid.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      valid_d    = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // in_ready is low here, so nothing new arrives this cycle
      if (deliver) begin
        data_d     = skid_dat_q;
        skid_vld_d = 1'b0;
      end
    end else if (!valid_q || deliver) begin
      // Main is free (or freeing): bypass the skid to keep 1-cycle latency
      valid_d = accept;
      if (accept) begin
        data_d = in_data;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_data;
    end
  end

  // Skid register state; reset empties it.
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_vld_q <= 1'b0;
      skid_dat_q <= RESET_VAL;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end
`else
  // Single-entry stage: ready whenever the held payload is absent or leaving this cycle.
  assign in_ready = ~valid_q | out_ready;

  // Next state: flush squashes (and discards a same-cycle accept); otherwise load when ready.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end
`endif

  // Main register and counter; reset overrides flush and handshakes. out_data keeps its value when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: table-driven streaming vectors plus hand-written stall/flush/reset sequences,
// with a queue scoreboard of held payloads checked every cycle at the falling edge.
// Honors PIPE_SKID_BUF_EN for the expected in_ready and capacity.
module tb_pipe_stage_reg;

  localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;
  localparam int          CNT_MAX = 15;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [3:0]  stall_cnt;

  pipe_stage_reg #(
    .DATA_W   (32),
    .RESET_VAL(RST_VAL),
    .CNT_W    (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] sb_q [$];
  logic [31:0] mdl_data;
  int          mdl_cnt;
  int          vec_cnt;
  int          miss_cnt;
  bit          chk_en;
  bit          got6;
  bit          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic fl, input logic rst);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
  endtask

  // One clock: compare outputs with the scoreboard at negedge, then advance the model at posedge.
  task automatic tick(input bit use_tbl, input logic tv, input logic [31:0] td);
    logic        acc, mv, ordy, fl, rst, exp_rdy;
    logic [31:0] din;
    @(negedge clock);
    mv = (sb_q.size() != 0);
`ifdef PIPE_SKID_BUF_EN
    exp_rdy = (sb_q.size() < 2);
`else
    exp_rdy = !mv || out_ready;
`endif
    if (chk_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
      chk("out_data", out_data, mdl_data);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("stall_cnt", {28'd0, stall_cnt}, mdl_cnt);
      if (use_tbl) begin
        chk("tbl_valid", {31'd0, out_valid}, {31'd0, tv});
        chk("tbl_data", out_data, td);
      end
    end
    acc  = in_valid && in_ready;
    ordy = out_ready;
    fl   = flush;
    rst  = reset;
    din  = in_data;
    @(posedge clock);
    last_acc = 1'b0;
    if (rst) begin
      sb_q.delete();
      mdl_cnt  = 0;
      mdl_data = RST_VAL;
    end else begin
      if (mv && !ordy && mdl_cnt != CNT_MAX) mdl_cnt++;
      if (mv && ordy) begin
        chk("order", out_data, sb_q[0]);
        void'(sb_q.pop_front());
      end
      if (fl) begin
        sb_q.delete();
      end else if (acc) begin
        sb_q.push_back(din);
        last_acc = 1'b1;
        if (din == 32'd6) got6 = 1'b1;
      end
      if (sb_q.size() != 0) mdl_data = sb_q[0];
    end
    chk_en = 1'b1;
    #1;
  endtask

  initial begin
    int nxt;
    vec_cnt  = 0;
    miss_cnt = 0;
    chk_en   = 1'b0;
    got6     = 1'b0;
    last_acc = 1'b0;
    mdl_cnt  = 0;
    mdl_data = RST_VAL;
    // Streaming 1..4 with out_ready high: each value one cycle after it is offered, no bubbles
    tbl[0] = '{iv: 1'b1, id: 32'd1, ordy: 1'b1, ev: 1'b0, ed: RST_VAL};
    tbl[1] = '{iv: 1'b1, id: 32'd2, ordy: 1'b1, ev: 1'b1, ed: 32'd1};
    tbl[2] = '{iv: 1'b1, id: 32'd3, ordy: 1'b1, ev: 1'b1, ed: 32'd2};
    tbl[3] = '{iv: 1'b1, id: 32'd4, ordy: 1'b1, ev: 1'b1, ed: 32'd3};
    tbl[4] = '{iv: 1'b0, id: 32'd0, ordy: 1'b1, ev: 1'b1, ed: 32'd4};
    tbl[5] = '{iv: 1'b0, id: 32'd0, ordy: 1'b1, ev: 1'b0, ed: 32'd4};

    // Reset for two cycles; the second is checked against reset values
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, 1'b0, 1'b0);
      tick(1'b1, tbl[i].ev, tbl[i].ed);
    end

    // Hold 5 under a 3-cycle stall while 6 is offered, then drain in order
    drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(!got6, 32'd6, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 32'd0);
    end
    chk("stall3", {28'd0, stall_cnt}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      drive(!got6, 32'd6, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 32'd0);
    end
    chk("got6", {31'd0, got6}, 32'd1);

    // Stage holds 7 (skid 8 when present); flush with 9 offered squashes everything
    drive(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    drive(1'b1, 32'd9, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 32'd0);
    end

    // Flush while delivering 10 and offering 11: 10 completes, 11 is discarded
    drive(1'b1, 32'd10, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    drive(1'b1, 32'd11, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 32'd0);
    end

    // Long stall: 4-bit counter saturates at 15 and survives flush
    drive(1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 32'd0);
    end
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    chk("sat_after_flush", {28'd0, stall_cnt}, 32'd15);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);

    // Reset mid-stall with the stage full, then first payload after reset
    drive(1'b1, 32'd13, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    drive(1'b1, 32'd14, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    drive(1'b1, 32'd15, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 32'd0);
    chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_data", out_data, RST_VAL);
    drive(1'b1, 32'd16, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_data", out_data, 32'd16);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 32'd0);

    // Random downstream readiness with a continuous upstream: order and no loss/duplication
    nxt = 100;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, nxt, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      tick(1'b0, 1'b0, 32'd0);
      if (last_acc) nxt++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 32'd0);
    end
    chk("drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
